// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Bundles the sequencer's control inputs and fetch/status outputs.
//   Clock and reset are kept outside as plain ports on the sequencer.
//   Signals:
//     stall, br_taken, br_target, halt_req, resume  -> into the sequencer
//     pc, pc_valid, flush, halted                   <- registered fetch/status
//     br_count, stall_count                         <- statistics counters
//   Modports: master (drives the control inputs), slave (the sequencer).
interface pc_seq_if #(
    parameter int PC_W = 8
);
    logic            stall;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            halt_req;
    logic            resume;
    logic [PC_W-1:0] pc;
    logic            pc_valid;
    logic            flush;
    logic            halted;
    logic [7:0]      br_count;
    logic [7:0]      stall_count;

    modport master (
        output stall, br_taken, br_target, halt_req, resume,
        input  pc, pc_valid, flush, halted, br_count, stall_count
    );

    modport slave (
        input  stall, br_taken, br_target, halt_req, resume,
        output pc, pc_valid, flush, halted, br_count, stall_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter sequencer for the 8-bit core. Owns the fetch PC and
//   arbitrates halt request, branch redirect, stall, exit-label halt and
//   sequential increment. A taken branch is followed by FLUSH_CYC bubble
//   cycles; fetching EXIT_PC halts the core until resume.
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  synchronous, active-high
//     bus    pc_seq_if.slave (control inputs, pc/pc_valid/flush/halted,
//            br_count/stall_count)
//   Optional feature macro: PC_SEQ_STATS_EN
//     defined     -> saturating taken-branch and stall-cycle counters
//     not defined -> br_count/stall_count tied to zero, no counter flops
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_RUN   | normal fetch: halt / branch / stall / exit / increment
//   S_FLUSH | bubbles after a taken branch, fcnt counts down to 1
//   S_HALT  | core stopped, waits for resume (without halt_req)
module pc_sequencer #(
    parameter int              PC_W      = 8,
    parameter logic [PC_W-1:0] RESET_PC  = 8'h04,
    parameter int              PC_STEP   = 4,
    parameter logic [PC_W-1:0] EXIT_PC   = 8'h80,
    parameter int              FLUSH_CYC = 2
) (
    input  logic      clk,
    input  logic      reset,
    pc_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t          r_state,    w_state_nxt;
    logic [PC_W-1:0] r_pc,       w_pc_nxt;
    logic            r_pc_valid, w_pc_valid_nxt;
    logic            r_flush,    w_flush_nxt;
    logic            r_halted,   w_halted_nxt;
    logic [2:0]      r_fcnt,     w_fcnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_flush    <= 1'b0;
            r_halted   <= 1'b0;
            r_fcnt     <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pc_valid <= w_pc_valid_nxt;
            r_flush    <= w_flush_nxt;
            r_halted   <= w_halted_nxt;
            r_fcnt     <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pc_valid_nxt = r_pc_valid;
        w_flush_nxt    = r_flush;
        w_halted_nxt   = r_halted;
        w_fcnt_nxt     = r_fcnt;

        case (r_state)
            S_RUN: begin
                if (bus.halt_req) begin
                    w_state_nxt    = S_HALT;
                    w_pc_valid_nxt = 1'b0;
                    w_halted_nxt   = 1'b1;
                end else if (bus.br_taken) begin
                    // branch beats a simultaneous stall
                    w_state_nxt    = S_FLUSH;
                    w_pc_nxt       = bus.br_target;
                    w_fcnt_nxt     = 3'(FLUSH_CYC);
                    w_flush_nxt    = 1'b1;
                    w_pc_valid_nxt = 1'b0;
                end else if (bus.stall) begin
                    w_state_nxt = S_RUN;
                end else if (r_pc == EXIT_PC && r_pc_valid) begin
                    w_state_nxt    = S_HALT;
                    w_pc_valid_nxt = 1'b0;
                    w_halted_nxt   = 1'b1;
                end else if (!r_pc_valid) begin
                    // first cycle out of reset: present RESET_PC as a real fetch
                    w_pc_valid_nxt = 1'b1;
                end else begin
                    w_pc_nxt = r_pc + PC_W'(PC_STEP);
                end
            end
            S_FLUSH: begin
                if (bus.halt_req) begin
                    w_state_nxt  = S_HALT;
                    w_flush_nxt  = 1'b0;
                    w_halted_nxt = 1'b1;
                end else begin
                    w_fcnt_nxt = r_fcnt - 3'd1;
                    if (r_fcnt == 3'd1) begin
                        w_state_nxt    = S_RUN;
                        w_flush_nxt    = 1'b0;
                        w_pc_valid_nxt = 1'b1;
                    end
                end
            end
            S_HALT: begin
                if (bus.resume && !bus.halt_req) begin
                    w_state_nxt    = S_RUN;
                    w_pc_nxt       = RESET_PC;
                    w_halted_nxt   = 1'b0;
                    w_pc_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    assign bus.pc       = r_pc;
    assign bus.pc_valid = r_pc_valid;
    assign bus.flush    = r_flush;
    assign bus.halted   = r_halted;

`ifdef PC_SEQ_STATS_EN
    logic       w_br_accept;
    logic       w_stall_hold;
    logic [7:0] r_br_count;
    logic [7:0] r_stall_count;

    assign w_br_accept  = (r_state == S_RUN) && bus.br_taken && !bus.halt_req;
    assign w_stall_hold = (r_state == S_RUN) && bus.stall && !bus.br_taken
                          && !bus.halt_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_count    <= 8'h00;
            r_stall_count <= 8'h00;
        end else begin
            if (w_br_accept && r_br_count != 8'hFF)
                r_br_count <= r_br_count + 8'd1;
            if (w_stall_hold && r_stall_count != 8'hFF)
                r_stall_count <= r_stall_count + 8'd1;
        end
    end

    assign bus.br_count    = r_br_count;
    assign bus.stall_count = r_stall_count;
`else
    assign bus.br_count    = 8'h00;
    assign bus.stall_count = 8'h00;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_seq_if #(.PC_W(8)) bus ();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model: plain variables, bubble cycles remaining instead of a state
    logic [7:0] m_pc;
    bit         m_valid, m_flush, m_halted;
    int         m_bubbles;
    int         m_brc, m_stc;

    localparam int FLUSH_CYC = 2;

    function automatic logic [26:0] obs_vec();
        return {bus.pc, bus.pc_valid, bus.flush, bus.halted, bus.br_count, bus.stall_count};
    endfunction

    function automatic logic [26:0] exp_vec();
        logic [7:0] b, s;
`ifdef PC_SEQ_STATS_EN
        b = 8'(m_brc);
        s = 8'(m_stc);
`else
        b = 8'h00;
        s = 8'h00;
`endif
        return {m_pc, m_valid, m_flush, m_halted, b, s};
    endfunction

    task automatic model_step();
        if (reset) begin
            m_pc = 8'h04; m_valid = 0; m_flush = 0; m_halted = 0;
            m_bubbles = 0; m_brc = 0; m_stc = 0;
        end else if (m_halted) begin
            if (bus.resume && !bus.halt_req) begin
                m_pc = 8'h04; m_valid = 1; m_halted = 0;
            end
        end else if (m_bubbles > 0) begin
            if (bus.halt_req) begin
                m_halted = 1; m_flush = 0; m_bubbles = 0; m_valid = 0;
            end else begin
                m_bubbles--;
                if (m_bubbles == 0) begin
                    m_flush = 0; m_valid = 1;
                end
            end
        end else if (bus.halt_req) begin
            m_halted = 1; m_valid = 0;
        end else if (bus.br_taken) begin
            m_pc = bus.br_target; m_bubbles = FLUSH_CYC; m_flush = 1; m_valid = 0;
            if (m_brc < 255) m_brc++;
        end else if (bus.stall) begin
            if (m_stc < 255) m_stc++;
        end else if (m_pc == 8'h80 && m_valid) begin
            m_halted = 1; m_valid = 0;
        end else if (!m_valid) begin
            m_valid = 1;
        end else begin
            m_pc = 8'((int'(m_pc) + 4) % 256);
        end
    endtask

    task automatic drive(input bit st, input bit br, input logic [7:0] tg,
                         input bit hr, input bit rs);
        bus.stall     = st;
        bus.br_taken  = br;
        bus.br_target = tg;
        bus.halt_req  = hr;
        bus.resume    = rs;
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // advance with idle inputs until the model presents a valid fetch of pc
    task automatic run_to(input logic [7:0] pc, input int budget);
        int n = 0;
        idle();
        while (!(m_pc == pc && m_valid && !m_halted) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            errors++;
            $display("FAIL run_to timeout: pc=%h wanted %h", bus.pc, pc);
        end
    endtask

    task automatic do_reset();
        reset = 1; idle();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        repeat (3) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_model: got %h want %h", obs_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.pc !== 8'h04 || bus.pc_valid !== 1'b0 || bus.flush !== 1'b0 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: pc=%h v=%b f=%b h=%b want 04 0 0 0",
                     bus.pc, bus.pc_valid, bus.flush, bus.halted);
        end
        reset = 0;
    endtask

    task automatic test_sequential();
        logic [7:0] seq [6] = '{8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
        idle();
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus.pc !== seq[i] || bus.pc_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_pc[%0d]: pc=%h v=%b want %h 1", i, bus.pc, bus.pc_valid, seq[i]);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL seq_model[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        run_to(8'h10, 50);
        drive(0, 1, 8'h38, 0, 0);
        tick();
        checks++;
        if (bus.pc !== 8'h38 || bus.flush !== 1'b1 || bus.pc_valid !== 1'b0) begin
            errors++;
            $display("FAIL br_redirect: pc=%h f=%b v=%b want 38 1 0", bus.pc, bus.flush, bus.pc_valid);
        end
        idle();
        tick();
        checks++;
        if (bus.flush !== 1'b1 || bus.pc_valid !== 1'b0) begin
            errors++;
            $display("FAIL br_bubble2: f=%b v=%b want 1 0", bus.flush, bus.pc_valid);
        end
        tick();
        checks++;
        if (bus.pc !== 8'h38 || bus.flush !== 1'b0 || bus.pc_valid !== 1'b1) begin
            errors++;
            $display("FAIL br_target_fetch: pc=%h f=%b v=%b want 38 0 1", bus.pc, bus.flush, bus.pc_valid);
        end
        tick();
        checks++;
        if (obs_vec() !== exp_vec() || bus.pc !== 8'h3C) begin
            errors++;
            $display("FAIL br_next: got %h want %h (pc 3C)", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_stall();
        logic [7:0] want_sc;
        do_reset();
        run_to(8'h20, 50);
        drive(1, 0, 8'h00, 0, 0);
        repeat (3) begin
            tick();
            checks++;
            if (bus.pc !== 8'h20 || bus.pc_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stall_hold: got %h want %h", obs_vec(), exp_vec());
            end
        end
`ifdef PC_SEQ_STATS_EN
        want_sc = 8'd3;
`else
        want_sc = 8'd0;
`endif
        checks++;
        if (bus.stall_count !== want_sc) begin
            errors++;
            $display("FAIL stall_count: got %0d want %0d", bus.stall_count, want_sc);
        end
        idle();
        tick();
        checks++;
        if (bus.pc !== 8'h24) begin
            errors++;
            $display("FAIL stall_release: pc=%h want 24", bus.pc);
        end
    endtask

    task automatic test_exit();
        drive(0, 1, 8'h80, 0, 0);
        tick();
        idle();
        tick();
        tick();
        checks++;
        if (bus.pc !== 8'h80 || bus.pc_valid !== 1'b1 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL exit_fetch: pc=%h v=%b h=%b want 80 1 0", bus.pc, bus.pc_valid, bus.halted);
        end
        tick();
        checks++;
        if (bus.pc !== 8'h80 || bus.pc_valid !== 1'b0 || bus.halted !== 1'b1) begin
            errors++;
            $display("FAIL exit_halt: pc=%h v=%b h=%b want 80 0 1", bus.pc, bus.pc_valid, bus.halted);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 0);
            tick();
            checks++;
            if (obs_vec() !== exp_vec() || bus.halted !== 1'b1 || bus.pc !== 8'h80) begin
                errors++;
                $display("FAIL halt_ignore[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        drive(0, 0, 8'h00, 1, 1);
        tick();
        checks++;
        if (bus.halted !== 1'b1 || bus.pc !== 8'h80) begin
            errors++;
            $display("FAIL resume_with_halt: h=%b pc=%h want 1 80", bus.halted, bus.pc);
        end
        drive(0, 0, 8'h00, 0, 1);
        tick();
        checks++;
        if (bus.pc !== 8'h04 || bus.pc_valid !== 1'b1 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL resume: pc=%h v=%b h=%b want 04 1 0", bus.pc, bus.pc_valid, bus.halted);
        end
        idle();
    endtask

    task automatic test_halt_in_flush();
        drive(0, 1, 8'h50, 0, 0);
        tick();
        drive(0, 0, 8'h00, 1, 0);
        tick();
        checks++;
        if (bus.halted !== 1'b1 || bus.flush !== 1'b0 || bus.pc !== 8'h50 || bus.pc_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_in_flush: h=%b f=%b pc=%h v=%b want 1 0 50 0",
                     bus.halted, bus.flush, bus.pc, bus.pc_valid);
        end
        idle();
        tick();
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (bus.pc !== 8'h04 || bus.halted !== 1'b0 || bus.pc_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_from_halt: got %h want %h", obs_vec(), exp_vec());
        end
        tick();
        checks++;
        if (bus.pc !== 8'h04 || bus.pc_valid !== 1'b1) begin
            errors++;
            $display("FAIL run_after_reset: pc=%h v=%b want 04 1", bus.pc, bus.pc_valid);
        end
    endtask

    task automatic test_wrap();
        drive(0, 1, 8'hFC, 0, 0);
        tick();
        idle();
        tick();
        tick();
        checks++;
        if (bus.pc !== 8'hFC || bus.pc_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_fc: pc=%h v=%b want FC 1", bus.pc, bus.pc_valid);
        end
        tick();
        checks++;
        if (bus.pc !== 8'h00 || bus.pc_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL wrap_00: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_branch_with_stall();
        drive(1, 1, 8'h44, 0, 0);
        tick();
        checks++;
        if (bus.pc !== 8'h44 || bus.flush !== 1'b1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL br_plus_stall: got %h want %h", obs_vec(), exp_vec());
        end
        drive(1, 1, 8'h99, 0, 0);
        tick();
        checks++;
        if (bus.pc !== 8'h44 || bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL flush_ignores_br: pc=%h f=%b want 44 1", bus.pc, bus.flush);
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [7:0] tg;
            tg = ($urandom_range(0, 3) == 0) ? 8'h78 : 8'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, tg,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
                bad++;
            end
        end
        reset = 0;
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        m_pc = 8'h04; m_valid = 0; m_flush = 0; m_halted = 0;
        m_bubbles = 0; m_brc = 0; m_stc = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_exit();
        test_halt_in_flush();
        test_wrap();
        test_branch_with_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
